mem_arbiter: RTL and testbench

- Arbitrates the single-port 4096x16 main memory (async read, sync write on clk) between two requesters: the CPU control unit and a DMA/loader port.
- Round-robin between the two, with a CPU lock so that read-modify-write sequences (ISZ, BSA) run atomically.
- Registers the winning request and drives the memory's address, write and data-in pins for exactly one access cycle.
- Acks the winner in that cycle and holds the read data for it.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// CPU, DMA and memory-pin bundle around mem_arbiter; slave is the arbiter side,
// master is the requesters plus the memory macro.
interface mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic          cpu_lock;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output mem_addr, mem_write, mem_din,
        input  mem_dout
    );

    modport master (
        output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  mem_addr, mem_write, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin CPU/DMA arbiter for a single-port async-read memory, with a CPU lock for RMW.
// Latency: req->ack 1 cycle, req->rdata 2 cycles; backpressure: req is held until its ack pulse.
module mem_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CPU_ACC = 2'd1;
    localparam logic [1:0] DMA_ACC = 2'd2;

    localparam int            CW       = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX);
    localparam logic          GNT_CPU  = 1'b0;
    localparam logic          GNT_DMA  = 1'b1;

    logic [1:0]    state;
    logic          last_grant;
    logic          locked;
    logic [CW-1:0] lock_cnt;
    logic [CW-1:0] lock_cnt_inc;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;

    logic cpu_elig;
    logic dma_elig;
    logic grant_cpu;
    logic grant_dma;

    // The port being served this cycle is masked, so its still-high req is not re-granted.
    always_comb begin
        cpu_elig     = bus.cpu_req && (state != CPU_ACC);
        dma_elig     = bus.dma_req && (state != DMA_ACC) && !(locked && (lock_cnt < LOCK_LIM));
        grant_cpu    = cpu_elig && (!dma_elig || (last_grant == GNT_DMA));
        grant_dma    = dma_elig && !grant_cpu;
        lock_cnt_inc = (lock_cnt == LOCK_LIM) ? lock_cnt : lock_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= GNT_DMA;
            locked      <= 1'b0;
            lock_cnt    <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            din_q       <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if ((state == CPU_ACC) && !we_q) begin
                cpu_rdata_q <= bus.mem_dout;
            end
            if ((state == DMA_ACC) && !we_q) begin
                dma_rdata_q <= bus.mem_dout;
            end

            // An unlocked CPU grant releases the lock for its own access cycle,
            // letting a waiting DMA follow the closing write of an RMW back-to-back.
            if (grant_cpu) begin
                state      <= CPU_ACC;
                addr_q     <= bus.cpu_addr;
                we_q       <= bus.cpu_we;
                din_q      <= bus.cpu_wdata;
                last_grant <= GNT_CPU;
                locked     <= bus.cpu_lock;
                lock_cnt   <= bus.cpu_lock ? lock_cnt_inc : '0;
            end else if (grant_dma) begin
                state      <= DMA_ACC;
                addr_q     <= bus.dma_addr;
                we_q       <= bus.dma_we;
                din_q      <= bus.dma_wdata;
                last_grant <= GNT_DMA;
                locked     <= 1'b0;
                lock_cnt   <= '0;
            end else begin
                state <= IDLE;
                we_q  <= 1'b0;
            end
        end
    end

    assign bus.cpu_ack   = (state == CPU_ACC);
    assign bus.dma_ack   = (state == DMA_ACC);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_write = we_q;
    assign bus.mem_din   = din_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed per-cycle vector bench for mem_arbiter with a behavioural 4Kx16 memory.
module tb_mem_arbiter;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    mem_arbiter_if #(.AW(12), .DW(16)) bus ();

    mem_arbiter #(.AW(12), .DW(16), .LOCK_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:4095] = '{default: 16'h0000};
    logic        pre_en;
    logic [11:0] pre_addr;
    logic [15:0] pre_dat;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_dat;
        else if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_din;
    end
    assign bus.mem_dout = mem[bus.mem_addr];

    typedef struct {
        logic        cr, cw, cl;
        logic [11:0] ca;
        logic [15:0] cd;
        logic        dr, dw;
        logic [11:0] da;
        logic [15:0] dd;
        logic [46:0] want;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    // want = {cpu_ack, dma_ack, mem_write, mem_addr, cpu_rdata, dma_rdata}
    task automatic add(input logic cr, input logic cw, input logic cl, input logic [11:0] ca,
                       input logic [15:0] cd, input logic dr, input logic dw, input logic [11:0] da,
                       input logic [15:0] dd, input logic eca, input logic eda, input logic emw,
                       input logic [11:0] ema, input logic [15:0] ecr, input logic [15:0] edr);
        vec_t v;
        v.cr = cr; v.cw = cw; v.cl = cl; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.want = {eca, eda, emw, ema, ecr, edr};
        vq.push_back(v);
    endtask

    task automatic clear_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_lock = 1'b0;
        bus.cpu_addr = 12'h000; bus.cpu_wdata = 16'h0000;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0;
        bus.dma_addr = 12'h000; bus.dma_wdata = 16'h0000;
    endtask

    // Entered and left at posedge+1; each row drives one cycle and checks that cycle's outputs.
    task automatic run_table(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            bus.cpu_req = vq[i].cr; bus.cpu_we = vq[i].cw; bus.cpu_lock = vq[i].cl;
            bus.cpu_addr = vq[i].ca; bus.cpu_wdata = vq[i].cd;
            bus.dma_req = vq[i].dr; bus.dma_we = vq[i].dw;
            bus.dma_addr = vq[i].da; bus.dma_wdata = vq[i].dd;
            check($sformatf("%s[%0d]", tag, i),
                  {17'h0, bus.cpu_ack, bus.dma_ack, bus.mem_write, bus.mem_addr,
                   bus.cpu_rdata, bus.dma_rdata},
                  {17'h0, vq[i].want});
            @(posedge clk);
            #1;
        end
        vq.delete();
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        pre_en = 1'b1; pre_addr = a; pre_dat = d;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; pre_en = 1'b0; pre_addr = 12'h000; pre_dat = 16'h0000;
        clear_inputs();
        @(posedge clk);
        #1;
        preload(12'h050, 16'hFFFF);
        preload(12'h053, 16'h0002);
        preload(12'h0F0, 16'hC0EF);
        rst_n = 1'b1;

        // CPU-only read of 0x050, then write/read at the top address 0xFFF
        add(Y,N,N,12'h050,16'h0000, N,N,12'h000,16'h0000, N,N,N,12'h000,16'h0000,16'h0000);
        add(Y,N,N,12'h050,16'h0000, N,N,12'h000,16'h0000, Y,N,N,12'h050,16'h0000,16'h0000);
        add(N,N,N,12'h000,16'h0000, N,N,12'h000,16'h0000, N,N,N,12'h050,16'hFFFF,16'h0000);
        add(Y,Y,N,12'hFFF,16'h1234, N,N,12'h000,16'h0000, N,N,N,12'h050,16'hFFFF,16'h0000);
        add(Y,Y,N,12'hFFF,16'h1234, N,N,12'h000,16'h0000, Y,N,Y,12'hFFF,16'hFFFF,16'h0000);
        add(Y,N,N,12'hFFF,16'h0000, N,N,12'h000,16'h0000, N,N,N,12'hFFF,16'hFFFF,16'h0000);
        add(Y,N,N,12'hFFF,16'h0000, N,N,12'h000,16'h0000, Y,N,N,12'hFFF,16'hFFFF,16'h0000);
        add(N,N,N,12'h000,16'h0000, N,N,12'h000,16'h0000, N,N,N,12'hFFF,16'h1234,16'h0000);
        run_table("cpu_rd");

        // Concurrent from reset: CPU reads 0x053, DMA writes 0x0FF, CPU reads 0x0FF back
        do_reset();
        add(Y,N,N,12'h053,16'h0000, Y,Y,12'h0FF,16'hABCD, N,N,N,12'h000,16'h0000,16'h0000);
        add(Y,N,N,12'h053,16'h0000, Y,Y,12'h0FF,16'hABCD, Y,N,N,12'h053,16'h0000,16'h0000);
        add(N,N,N,12'h000,16'h0000, Y,Y,12'h0FF,16'hABCD, N,Y,Y,12'h0FF,16'h0002,16'h0000);
        add(Y,N,N,12'h0FF,16'h0000, N,N,12'h000,16'h0000, N,N,N,12'h0FF,16'h0002,16'h0000);
        add(Y,N,N,12'h0FF,16'h0000, N,N,12'h000,16'h0000, Y,N,N,12'h0FF,16'h0002,16'h0000);
        add(N,N,N,12'h000,16'h0000, N,N,12'h000,16'h0000, N,N,N,12'h0FF,16'hABCD,16'h0000);
        run_table("concur");

        // Both held: strict alternation CPU, DMA, CPU, ...
        do_reset();
        for (int k = 0; k < 12; k++)
            add(k < 10, N, N, 12'h050, 16'h0000, k < 11, N, 12'h053, 16'h0000,
                (k >= 1) && (k <= 10) && (k % 2 == 1),
                (k >= 2) && (k <= 10) && (k % 2 == 0), N,
                (k == 0) ? 12'h000 : ((k == 11) ? 12'h053 : ((k % 2 == 1) ? 12'h050 : 12'h053)),
                (k >= 2) ? 16'hFFFF : 16'h0000, (k >= 3) ? 16'h0002 : 16'h0000);
        run_table("rr");

        // Lock held: DMA forced through after the 8th locked CPU grant, lock count restarts
        do_reset();
        for (int k = 0; k < 20; k++)
            add(Y, N, Y, 12'h050, 16'h0000, Y, N, 12'h053, 16'h0000,
                (k % 2 == 1), (k == 16), N,
                (k == 0) ? 12'h000 : ((k == 16) ? 12'h053 : 12'h050),
                (k >= 2) ? 16'hFFFF : 16'h0000, (k >= 17) ? 16'h0002 : 16'h0000);
        run_table("lock_to");

        // RMW: locked read, unlocked write of 0, DMA right after, then read back 0
        do_reset();
        add(Y,N,Y,12'h050,16'h0000, Y,N,12'h053,16'h0000, N,N,N,12'h000,16'h0000,16'h0000);
        add(Y,N,Y,12'h050,16'h0000, Y,N,12'h053,16'h0000, Y,N,N,12'h050,16'h0000,16'h0000);
        add(Y,Y,N,12'h050,16'h0000, Y,N,12'h053,16'h0000, N,N,N,12'h050,16'hFFFF,16'h0000);
        add(Y,Y,N,12'h050,16'h0000, Y,N,12'h053,16'h0000, Y,N,Y,12'h050,16'hFFFF,16'h0000);
        add(N,N,N,12'h000,16'h0000, Y,N,12'h053,16'h0000, N,Y,N,12'h053,16'hFFFF,16'h0000);
        add(Y,N,N,12'h050,16'h0000, N,N,12'h000,16'h0000, N,N,N,12'h053,16'hFFFF,16'h0002);
        add(Y,N,N,12'h050,16'h0000, N,N,12'h000,16'h0000, Y,N,N,12'h050,16'hFFFF,16'h0002);
        add(N,N,N,12'h000,16'h0000, N,N,12'h000,16'h0000, N,N,N,12'h050,16'h0000,16'h0002);
        run_table("rmw");

        // Reset in the middle of a DMA write cycle
        do_reset();
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 12'h0F0; bus.dma_wdata = 16'h0123;
        @(posedge clk);
        #1;
        check("rst_wr_acc", {bus.cpu_ack, bus.dma_ack, bus.mem_write, bus.mem_addr, bus.mem_din},
              {1'b0, 1'b1, 1'b1, 12'h0F0, 16'h0123});
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_wr_abort", {bus.cpu_ack, bus.dma_ack, bus.mem_write, bus.mem_addr, bus.mem_din},
              {1'b0, 1'b0, 1'b0, 12'h000, 16'h0000});
        clear_inputs();
        @(posedge clk);
        #1;
        check("rst_wr_mem", {48'h0, mem[12'h0F0]}, 64'h0000_0000_0000_C0EF);
        rst_n = 1'b1;
        add(Y,N,N,12'h0F0,16'h0000, N,N,12'h000,16'h0000, N,N,N,12'h000,16'h0000,16'h0000);
        add(Y,N,N,12'h0F0,16'h0000, N,N,12'h000,16'h0000, Y,N,N,12'h0F0,16'h0000,16'h0000);
        add(N,N,N,12'h000,16'h0000, N,N,12'h000,16'h0000, N,N,N,12'h0F0,16'hC0EF,16'h0000);
        run_table("rst_rd");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
